regfile_wr_arbiter: RTL and testbench

- Owns the single register-file write port (WE3/A3/WD3) and shares it between two sources.
  - Pipeline writeback: fixed timing, cannot be back-pressured.
  - Auxiliary long-latency unit (multi-cycle divider, load miss): valid/ready handshake.
- After reset, sequences a clear of x1..x31 before the pipeline may run.
- Sits between the WB stage and the register file.

---
 rtl/regfile_wr_arbiter_if.sv | 27 ++
 rtl/regfile_wr_arbiter.sv | 141 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the WB stage, the aux long-latency unit and the regfile write arbiter.
interface regfile_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wb_valid;
  logic [4:0]            wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  aux_valid;
  logic [4:0]            aux_addr;
  logic [DATA_WIDTH-1:0] aux_data;
  logic                  aux_ready;
  logic                  rf_we;
  logic [4:0]            rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  init_busy;
  logic                  stall_o;

  modport master (
    output wb_valid, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    input  aux_ready, rf_we, rf_addr, rf_wdata, init_busy, stall_o
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    output aux_ready, rf_we, rf_addr, rf_wdata, init_busy, stall_o
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Owns the regfile write port: clears x1..x31 after reset, then arbitrates WB vs. a queued aux unit.
// Optional statistics counters are enabled with `define REGFILE_ARB_STATS_EN.
module regfile_wr_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wr_arbiter_if.slave bus
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [31:0]         stat_wb_writes,
  output logic [31:0]         stat_aux_writes,
  output logic [15:0]         stat_aux_kills,
  output logic [15:0]         stat_stalls
`endif
);

  localparam int IW = $clog2(AUX_DEPTH);
  localparam int PW = IW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state;
  logic [4:0]            clr_cnt;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [SW-1:0]         starve;
  logic [4:0]            q_addr [AUX_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [AUX_DEPTH];

  logic                  q_empty, q_full, push, pop;
  logic                  wb_issue, aux_issue, head_hit, starve_hit;
  logic [4:0]            head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign q_empty   = (wr_ptr == rd_ptr);
  assign q_full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign head_addr = q_addr[rd_ptr[IW-1:0]];
  assign head_data = q_data[rd_ptr[IW-1:0]];

  // Ready depends only on registered occupancy, so a same-cycle pop never feeds back into it.
  assign bus.aux_ready = !q_full && (state == ST_RUN);
  assign push          = bus.aux_valid && bus.aux_ready;

  assign wb_issue   = (state == ST_RUN) && bus.wb_valid;
  assign aux_issue  = (state == ST_RUN) && !bus.wb_valid && !q_empty;
  // An aux result older than a same-address writeback must be dropped, not written later.
  assign head_hit   = wb_issue && !q_empty && (head_addr == bus.wb_addr);
  assign pop        = aux_issue || head_hit;
  assign starve_hit = wb_issue && !q_empty && (starve == SW'(STARVE_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_INIT;
      clr_cnt       <= 5'd1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      starve        <= '0;
      bus.rf_we     <= 1'b0;
      bus.rf_addr   <= 5'd0;
      bus.rf_wdata  <= '0;
      bus.init_busy <= 1'b1;
      bus.stall_o   <= 1'b0;
    end else begin
      bus.stall_o <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        ST_INIT: begin
          bus.rf_we    <= 1'b1;
          bus.rf_addr  <= clr_cnt;
          bus.rf_wdata <= '0;
          clr_cnt      <= clr_cnt + 5'd1;
          if (clr_cnt == 5'd31) begin
            state         <= ST_RUN;
            bus.init_busy <= 1'b0;
          end
        end
        default: begin
          if (wb_issue) begin
            bus.rf_we    <= (bus.wb_addr != 5'd0);
            bus.rf_addr  <= bus.wb_addr;
            bus.rf_wdata <= bus.wb_data;
          end else if (aux_issue) begin
            bus.rf_we    <= (head_addr != 5'd0);
            bus.rf_addr  <= head_addr;
            bus.rf_wdata <= head_data;
          end else begin
            bus.rf_we    <= 1'b0;
          end

          if (q_empty || aux_issue) begin
            starve <= '0;
          end else if (wb_issue) begin
            if (starve_hit) begin
              starve      <= '0;
              bus.stall_o <= 1'b1;
            end else begin
              starve <= starve + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr[IW-1:0]] <= bus.aux_addr;
      q_data[wr_ptr[IW-1:0]] <= bus.aux_data;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // INIT clears and x0 writes are not real writes, so they are excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wb_writes  <= '0;
      stat_aux_writes <= '0;
      stat_aux_kills  <= '0;
      stat_stalls     <= '0;
    end else begin
      if (wb_issue && bus.wb_addr != 5'd0) stat_wb_writes  <= sat_inc32(stat_wb_writes);
      if (aux_issue && head_addr != 5'd0)  stat_aux_writes <= sat_inc32(stat_aux_writes);
      if (head_hit)                        stat_aux_kills  <= sat_inc16(stat_aux_kills);
      if (starve_hit)                      stat_stalls     <= sat_inc16(stat_stalls);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: init clear, WB/aux arbitration, stale kill, starvation, x0.
module tb_regfile_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DATA_WIDTH(32)) bus ();

`ifdef REGFILE_ARB_STATS_EN
  logic [31:0] stat_wb_writes, stat_aux_writes;
  logic [15:0] stat_aux_kills, stat_stalls;
`endif

  regfile_wr_arbiter #(
    .DATA_WIDTH  (32),
    .AUX_DEPTH   (2),
    .STARVE_LIMIT(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .stat_wb_writes (stat_wb_writes),
    .stat_aux_writes(stat_aux_writes),
    .stat_aux_kills (stat_aux_kills),
    .stat_stalls    (stat_stalls)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  task automatic drive_aux(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.aux_valid = v;
    bus.aux_addr  = a;
    bus.aux_data  = d;
  endtask

  task automatic expect_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"}, {31'd0, bus.rf_we}, {31'd0, we});
    if (we) begin
      check({tag, "_addr"}, {27'd0, bus.rf_addr}, {27'd0, a});
      check({tag, "_data"}, bus.rf_wdata, d);
    end
  endtask

  // The pipeline must never present a writeback while a forced bubble is requested.
  always @(negedge clk) begin
    if (!rst && bus.stall_o) begin
      total++;
      assert (bus.wb_valid === 1'b0) else begin
        bad++;
        $error("FAIL stall_protocol: wb_valid=%b expected=0", bus.wb_valid);
      end
    end
  end

  initial begin
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_aux(1'b0, 5'd0, 32'd0);

    // Reset values while rst is held
    tick();
    tick();
    check("rst_we", {31'd0, bus.rf_we}, 32'd0);
    check("rst_addr", {27'd0, bus.rf_addr}, 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    check("rst_ready", {31'd0, bus.aux_ready}, 32'd0);
    check("rst_busy", {31'd0, bus.init_busy}, 32'd1);

    // Partial INIT, then asynchronous reset mid-sequence
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    expect_wr("midinit", 1'b1, 5'd5, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_we", {31'd0, bus.rf_we}, 32'd0);
    check("async_rst_addr", {27'd0, bus.rf_addr}, 32'd0);
    check("async_rst_busy", {31'd0, bus.init_busy}, 32'd1);
    tick();
    rst = 1'b0;

    // Full INIT: x1..x31 cleared, traffic offered meanwhile is ignored
    drive_wb(1'b1, 5'd5, 32'h1234_5678);
    drive_aux(1'b1, 5'd6, 32'h0000_0066);
    for (int k = 1; k <= 31; k++) begin
      if (k == 31) begin
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_aux(1'b0, 5'd0, 32'd0);
      end else begin
        check("init_ready", {31'd0, bus.aux_ready}, 32'd0);
      end
      tick();
      expect_wr("init", 1'b1, 5'(k), 32'd0);
      check("init_busy", {31'd0, bus.init_busy}, (k < 31) ? 32'd1 : 32'd0);
    end
    tick();
    check("run_idle_we", {31'd0, bus.rf_we}, 32'd0);
    check("run_busy", {31'd0, bus.init_busy}, 32'd0);
    check("run_ready", {31'd0, bus.aux_ready}, 32'd1);

    // Plain writeback
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    expect_wr("wb5", 1'b1, 5'd5, 32'hDEAD_BEEF);
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    check("wb_idle", {31'd0, bus.rf_we}, 32'd0);

    // Two aux writes, issued in order
    drive_aux(1'b1, 5'd7, 32'h11);
    tick();
    check("aux_push_idle", {31'd0, bus.rf_we}, 32'd0);
    drive_aux(1'b1, 5'd8, 32'h22);
    tick();
    expect_wr("aux7", 1'b1, 5'd7, 32'h11);
    drive_aux(1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("aux8", 1'b1, 5'd8, 32'h22);
    tick();
    check("aux_drained", {31'd0, bus.rf_we}, 32'd0);

    // Fill the queue while WB holds the port; the third offer is refused
    drive_wb(1'b1, 5'd20, 32'hA0);
    drive_aux(1'b1, 5'd12, 32'hC1);
    tick();
    expect_wr("blk_wb_a", 1'b1, 5'd20, 32'hA0);
    drive_aux(1'b1, 5'd13, 32'hC2);
    tick();
    expect_wr("blk_wb_b", 1'b1, 5'd20, 32'hA0);
    drive_aux(1'b1, 5'd14, 32'hC3);
    check("full_ready", {31'd0, bus.aux_ready}, 32'd0);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_aux(1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("blk_aux12", 1'b1, 5'd12, 32'hC1);
    check("ready_after_pop", {31'd0, bus.aux_ready}, 32'd1);
    tick();
    expect_wr("blk_aux13", 1'b1, 5'd13, 32'hC2);
    tick();
    check("refused_not_queued", {31'd0, bus.rf_we}, 32'd0);

    // Stale kill: same-address writeback discards the queued aux result
    drive_aux(1'b1, 5'd9, 32'h99);
    tick();
    drive_aux(1'b0, 5'd0, 32'd0);
    drive_wb(1'b1, 5'd9, 32'h55);
    tick();
    expect_wr("kill_wb9", 1'b1, 5'd9, 32'h55);
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    check("kill_no_stale", {31'd0, bus.rf_we}, 32'd0);
    tick();
    check("kill_empty", {31'd0, bus.rf_we}, 32'd0);

    // Starvation: 8 blocked cycles force one bubble, then the aux head issues
    drive_aux(1'b1, 5'd4, 32'h44);
    tick();
    drive_aux(1'b0, 5'd0, 32'd0);
    drive_wb(1'b1, 5'd3, 32'h33);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("starve_stall", {31'd0, bus.stall_o}, (i == 8) ? 32'd1 : 32'd0);
      expect_wr("starve_wb3", 1'b1, 5'd3, 32'h33);
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("starve_aux4", 1'b1, 5'd4, 32'h44);
    check("stall_one_cycle", {31'd0, bus.stall_o}, 32'd0);
    tick();
    check("starve_idle", {31'd0, bus.rf_we}, 32'd0);

    // x0 writes from both sources are swallowed; the aux x0 entry still pops
    drive_aux(1'b1, 5'd0, 32'hF0);
    tick();
    drive_aux(1'b1, 5'd6, 32'h66);
    tick();
    check("aux_x0_we", {31'd0, bus.rf_we}, 32'd0);
    drive_aux(1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("aux6_after_x0", 1'b1, 5'd6, 32'h66);
    drive_wb(1'b1, 5'd0, 32'hAB);
    tick();
    check("wb_x0_we", {31'd0, bus.rf_we}, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    check("final_idle", {31'd0, bus.rf_we}, 32'd0);

`ifdef REGFILE_ARB_STATS_EN
    check("stat_wb", stat_wb_writes, 32'd13);
    check("stat_aux", stat_aux_writes, 32'd6);
    check("stat_kills", {16'd0, stat_aux_kills}, 32'd1);
    check("stat_stalls", {16'd0, stat_stalls}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
